// File: rtl/alu.sv
// Registered arithmetic/logic unit for the processor/UART datapath.
// Two unsigned DATA_WIDTH-bit operands produce a 2*DATA_WIDTH-bit result
// one clock after an enabled request.
//
// Valid semantics: alu_result_valid is high for exactly the cycle after an
// edge where enable was sampled high, and alu_result then carries f(A,B) for
// that request. There is no backpressure, so a result is never stalled and
// a request is accepted on every edge where enable is high. With enable low,
// alu_result holds its last value and alu_result_valid drops.
module alu #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH-1:0]     A,
  input  logic [DATA_WIDTH-1:0]     B,
  input  logic [3:0]                alu_function,
  input  logic                      enable,
  output logic [2*DATA_WIDTH-1:0]   alu_result,
  output logic                      alu_result_valid
);

  localparam int RW = 2 * DATA_WIDTH;

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_MUL  = 4'b0010;
  localparam logic [3:0] FN_DIV  = 4'b0011;
  localparam logic [3:0] FN_AND  = 4'b0100;
  localparam logic [3:0] FN_OR   = 4'b0101;
  localparam logic [3:0] FN_NAND = 4'b0110;
  localparam logic [3:0] FN_NOR  = 4'b0111;
  localparam logic [3:0] FN_XOR  = 4'b1000;
  localparam logic [3:0] FN_XNOR = 4'b1001;
  localparam logic [3:0] FN_EQ   = 4'b1010;
  localparam logic [3:0] FN_GT   = 4'b1011;
  localparam logic [3:0] FN_LT   = 4'b1100;
  localparam logic [3:0] FN_SHR  = 4'b1101;
  localparam logic [3:0] FN_SHL  = 4'b1110;

  // Operands widened once so every arithmetic op naturally works at RW bits
  // (carry, borrow-wrap and full product all fall out of the width).
  logic [RW-1:0]         a_ext;
  logic [RW-1:0]         b_ext;
  logic [DATA_WIDTH-1:0] quotient;
  logic [RW-1:0]         next_result;

  assign a_ext = {{DATA_WIDTH{1'b0}}, A};
  assign b_ext = {{DATA_WIDTH{1'b0}}, B};

  // Divide-by-zero is defined as 0 rather than left to the divider.
  assign quotient = (B == '0) ? '0 : (A / B);

  // Combinational function select; every code, including reserved, is defined.
  always_comb begin
    next_result = '0;
    unique case (alu_function)
      FN_ADD:  next_result = a_ext + b_ext;
      FN_SUB:  next_result = a_ext - b_ext;
      FN_MUL:  next_result = a_ext * b_ext;
      FN_DIV:  next_result = {{DATA_WIDTH{1'b0}}, quotient};
      FN_AND:  next_result = {{DATA_WIDTH{1'b0}}, A & B};
      FN_OR:   next_result = {{DATA_WIDTH{1'b0}}, A | B};
      FN_NAND: next_result = {{DATA_WIDTH{1'b0}}, ~(A & B)};
      FN_NOR:  next_result = {{DATA_WIDTH{1'b0}}, ~(A | B)};
      FN_XOR:  next_result = {{DATA_WIDTH{1'b0}}, A ^ B};
      FN_XNOR: next_result = {{DATA_WIDTH{1'b0}}, ~(A ^ B)};
      FN_EQ:   next_result = {{(RW-1){1'b0}}, (A == B)};
      FN_GT:   next_result = {{(RW-1){1'b0}}, (A > B)};
      FN_LT:   next_result = {{(RW-1){1'b0}}, (A < B)};
      FN_SHR:  next_result = a_ext >> 1;
      FN_SHL:  next_result = a_ext << 1;
      default: next_result = '0;
    endcase
  end

  // Result register: loads only on an enabled request, otherwise holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_result <= '0;
    end else if (enable) begin
      alu_result <= next_result;
    end
  end

  // Valid register: follows enable with one cycle of latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_result_valid <= 1'b0;
    end else begin
      alu_result_valid <= enable;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu: each scenario task drives vectors and checks
// the registered result against hand-computed values.
module tb_alu;

  localparam int W = 8;

  logic           clk;
  logic           reset_n;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [3:0]     fn;
  logic           enable;
  logic [2*W-1:0] alu_result;
  logic           alu_result_valid;

  int n_cmp;
  int n_err;

  alu #(.DATA_WIDTH(W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .A                (a),
    .B                (b),
    .alu_function     (fn),
    .enable           (enable),
    .alu_result       (alu_result),
    .alu_result_valid (alu_result_valid)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one enabled request on the falling edge, then sample #1 after
  // the next rising edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [3:0] ifn);
    @(negedge clk);
    a = ia;
    b = ib;
    fn = ifn;
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    enable = 1'b1;
    a = 8'hFF;
    b = 8'h01;
    fn = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (alu_result !== 16'h0000 || alu_result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: result=%h valid=%b expected 0000/0", alu_result, alu_result_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    issue(8'hFF, 8'hFF, 4'h0);
    n_cmp++;
    if (alu_result !== 16'h01FE || alu_result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: result=%h valid=%b expected 01FE/1", alu_result, alu_result_valid);
    end
    // Asynchronous assertion between edges must clear immediately.
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (alu_result !== 16'h0000 || alu_result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: result=%h valid=%b expected 0000/0", alu_result, alu_result_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b0;
  endtask

  task automatic test_vectors(input string name, input logic [W-1:0] va[],
                              input logic [W-1:0] vb[], input logic [3:0] vf[],
                              input logic [2*W-1:0] ve[]);
    for (int i = 0; i < va.size(); i++) begin
      issue(va[i], vb[i], vf[i]);
      n_cmp++;
      if (alu_result !== ve[i] || alu_result_valid !== 1'b1) begin
        n_err++;
        $display("FAIL %s[%0d] fn=%h: result=%h valid=%b expected %h/1",
                 name, i, vf[i], alu_result, alu_result_valid, ve[i]);
      end
    end
  endtask

  task automatic test_arith;
    logic [W-1:0]   va[] = '{8'h54, 8'h54, 8'h54, 8'h54};
    logic [W-1:0]   vb[] = '{8'h2A, 8'h2A, 8'h2A, 8'h2A};
    logic [3:0]     vf[] = '{4'h0, 4'h1, 4'h2, 4'h3};
    logic [2*W-1:0] ve[] = '{16'h007E, 16'h002A, 16'h0DC8, 16'h0002};
    test_vectors("arith", va, vb, vf, ve);
  endtask

  task automatic test_logic;
    logic [W-1:0]   va[] = '{8'h54, 8'hF4, 8'hF4, 8'hF4, 8'hF4, 8'hF4};
    logic [W-1:0]   vb[] = '{8'h2F, 8'h2C, 8'h2C, 8'h2C, 8'h2C, 8'h2C};
    logic [3:0]     vf[] = '{4'h4, 4'h5, 4'h8, 4'h6, 4'h7, 4'h9};
    logic [2*W-1:0] ve[] = '{16'h0004, 16'h00FC, 16'h00D8, 16'h00DB, 16'h0003, 16'h0027};
    test_vectors("logic", va, vb, vf, ve);
  endtask

  task automatic test_boundary;
    logic [W-1:0]   va[] = '{8'hFF, 8'hFF, 8'h10, 8'h37, 8'h81, 8'h81};
    logic [W-1:0]   vb[] = '{8'hFF, 8'hFF, 8'h20, 8'h00, 8'h00, 8'h00};
    logic [3:0]     vf[] = '{4'h0, 4'h2, 4'h1, 4'h3, 4'hE, 4'hD};
    logic [2*W-1:0] ve[] = '{16'h01FE, 16'hFE01, 16'hFFF0, 16'h0000, 16'h0102, 16'h0040};
    test_vectors("boundary", va, vb, vf, ve);
  endtask

  task automatic test_compare;
    logic [W-1:0]   va[] = '{8'h5A, 8'h5B, 8'h5B, 8'h5A, 8'h5A, 8'h5B, 8'h5B};
    logic [W-1:0]   vb[] = '{8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5B, 8'h5A, 8'h5A};
    logic [3:0]     vf[] = '{4'hA, 4'hB, 4'hC, 4'hB, 4'hC, 4'hA, 4'hF};
    logic [2*W-1:0] ve[] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000};
    test_vectors("compare", va, vb, vf, ve);
  endtask

  task automatic test_enable;
    issue(8'h54, 8'h2A, 4'h0);
    n_cmp++;
    if (alu_result !== 16'h007E || alu_result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL enable_first: result=%h valid=%b expected 007E/1", alu_result, alu_result_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      enable = 1'b0;
      a = 8'h11 + 8'(i);
      b = 8'h22;
      fn = 4'h2;
      @(posedge clk);
      #1;
      n_cmp++;
      if (alu_result !== 16'h007E || alu_result_valid !== 1'b0) begin
        n_err++;
        $display("FAIL enable_hold[%0d]: result=%h valid=%b expected 007E/0", i, alu_result, alu_result_valid);
      end
    end
    issue(8'h01, 8'h02, 4'h0);
    n_cmp++;
    if (alu_result !== 16'h0003 || alu_result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL enable_resume: result=%h valid=%b expected 0003/1", alu_result, alu_result_valid);
    end
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0]   va[] = '{8'h03, 8'h80, 8'hC8, 8'h0F};
    logic [W-1:0]   vb[] = '{8'h05, 8'h80, 8'h0A, 8'hF0};
    logic [3:0]     vf[] = '{4'h2, 4'h0, 4'h3, 4'h5};
    logic [2*W-1:0] ve[] = '{16'h000F, 16'h0100, 16'h0014, 16'h00FF};
    test_vectors("b2b", va, vb, vf, ve);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    enable = 1'b0;
    a = '0;
    b = '0;
    fn = '0;
    test_reset();
    test_arith();
    test_logic();
    test_boundary();
    test_compare();
    test_enable();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
